any1_branch_eval_pipe: RTL and testbench
========================================

Name: any1_branch_eval_pipe

Overview:
- Pipelined, parametrised branch resolution unit for the ANY-1 core, fed by issue logic and draining to the fetch redirect and commit paths.
- Buffers branch requests in a small FIFO and evaluates the branch condition, including bit-test and always modes, on WID-bit operands.
- Computes the branch target and redirect PC, flags mispredictions against the predictor's guess, and keeps saturating branch and mispredict statistics.
- Valid/ready handshakes on both sides; synchronous flush.

Parameters:
WID, 64, operand width in bits
PCW, 32, PC/target width in bits
TAGW, 6, request tag width (ROB/tracking id)
DEPTH, 4, input FIFO entries; power of two, >=2
INC, 4, sequential PC increment for the not-taken path
CNTW, 32, statistics counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard all buffered and in-flight requests
in_valid_i  in  1  request valid
in_ready_o  out  1  FIFO can accept
op_i  in  4  condition: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 BBS, 7 BBC, 8 ALWAYS, 9-15 NEVER
a_i  in  WID  operand a
b_i  in  WID  operand b (bit index for BBS/BBC)
pc_i  in  PCW  branch PC
disp_i  in  PCW  signed displacement
pred_taken_i  in  1  predictor's taken guess
tag_i  in  TAGW  request tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts
takb_o  out  1  resolved taken
target_o  out  PCW  pc + disp
redirect_pc_o  out  PCW  takb ? target : pc + INC
mispredict_o  out  1  takb != pred_taken
tag_o  out  TAGW  echoed tag
br_count_o  out  CNTW  completed branches
mp_count_o  out  CNTW  completed mispredicts

Behaviour:
- Reset (rst_i high at clock edge): FIFO empty, stage-1 and stage-2 valid cleared, all outputs 0, counters 0. Reset overrides flush and all handshakes.
- Accept: a request is accepted when in_valid_i & in_ready_o.
  - in_ready_o = (fifo_count < DEPTH) & ~flush_i.
  - Pointers wrap modulo DEPTH; occupancy is held as a separate count, 0..DEPTH.
- Stage 1 (evaluate):
  - Takes the FIFO head when stage 1 is empty or advancing; stage 1 advances when stage 2 is empty or (out_valid_o & out_ready_i).
  - Registers takb, target, mispredict, redirect and tag.
  - Push and pop in the same cycle leaves the count unchanged. An empty FIFO with a same-cycle push does not bypass: the entry pops on the next cycle.
- Stage 2 (output register): holds its result stable with out_valid_o high until out_ready_i; no data change while valid & ~ready.
- Latency: with the pipeline empty and no stalls, a request accepted at edge N presents out_valid_o after edge N+2. Throughput is 1 per cycle sustained.
- Conditions:
  - LT/GE signed, LTU/GEU unsigned, full WID compare.
  - BBS/BBC test a[b[$clog2(WID)-1:0]]; upper bits of b are ignored.
  - ALWAYS gives takb=1; codes 9-15 give takb=0.
- Arithmetic:
  - target = pc + disp, modulo 2^PCW (wraps, no overflow flag).
  - pc + INC also wraps modulo 2^PCW.
- Counters:
  - On each output transfer, br_count_o increments, and mp_count_o increments if mispredict_o.
  - Both saturate at all-ones and are not cleared by flush.
- Flush (flush_i high at edge):
  - FIFO emptied; stage-1 and stage-2 valid cleared.
  - An input on the flush cycle is not accepted.
  - An output transfer occurring on the flush cycle (out_valid_o & out_ready_i) is complete and counted.
- Full FIFO: in_ready_o low; in_valid_i is held by the producer and ignored until space frees.

Test Plan:
- Reset, then op=EQ, a=b=64'h5, pc=32'h1000, disp=32'h20, pred=0 -> after 2 cycles: takb=1, target=32'h1020, redirect=32'h1020, mispredict=1, br_count=1, mp_count=1.
- op=LT a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> takb=1; same operands with op=LTU -> takb=0, redirect=pc+4. op=BBS a=64'h8000_0000_0000_0000, b=64'h13F -> takb=1; op=BBC with the same operands -> takb=0.
- Hold out_ready_i=0 and push 7 requests -> in_ready_o drops after DEPTH+2=6 accepted, output stays stable. Release ready -> 6 results in order, tags 0..5, one per cycle.
- Back-to-back 100 random requests with out_ready_i=1 -> results match a golden model in order; sustained 1/cycle; counters equal the model's counts.
- Fill the pipe, then pulse flush_i with in_valid_i=1 -> no results emerge after the flush cycle, the flush-cycle input is dropped, and counters keep their prior values.
- pc=32'hFFFF_FFFC, disp=32'h8, op=ALWAYS -> target=32'h0000_0004. CNTW=4 build with 20 transfers -> br_count=4'hF (saturated).

Source files
------------

// File: rtl/any1_branch_eval_pipe.sv
// rtl/any1_branch_eval_pipe.sv - ANY-1 branch resolution pipe: request FIFO, evaluate stage, output register.
module any1_branch_eval_pipe #(
  parameter int WID   = 64,
  parameter int PCW   = 32,
  parameter int TAGW  = 6,
  parameter int DEPTH = 4,
  parameter int INC   = 4,
  parameter int CNTW  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [WID-1:0]  a_i,
  input  logic [WID-1:0]  b_i,
  input  logic [PCW-1:0]  pc_i,
  input  logic [PCW-1:0]  disp_i,
  input  logic            pred_taken_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            takb_o,
  output logic [PCW-1:0]  target_o,
  output logic [PCW-1:0]  redirect_pc_o,
  output logic            mispredict_o,
  output logic [TAGW-1:0] tag_o,
  output logic [CNTW-1:0] br_count_o,
  output logic [CNTW-1:0] mp_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WID);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [3:0]      op_mem   [DEPTH];
  logic [WID-1:0]  a_mem    [DEPTH];
  logic [WID-1:0]  b_mem    [DEPTH];
  logic [PCW-1:0]  pc_mem   [DEPTH];
  logic [PCW-1:0]  disp_mem [DEPTH];
  logic            pred_mem [DEPTH];
  logic [TAGW-1:0] tag_mem  [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [CNTW-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  logic            s1_takb_q, s1_mp_q;
  logic [PCW-1:0]  s1_target_q, s1_redirect_q;
  logic [TAGW-1:0] s1_tag_q;
  logic            s2_takb_q, s2_mp_q;
  logic [PCW-1:0]  s2_target_q, s2_redirect_q;
  logic [TAGW-1:0] s2_tag_q;

  logic            push, pop, s1_adv, s1_move, xfer;
  logic [3:0]      h_op;
  logic [WID-1:0]  h_a, h_b;
  logic [PCW-1:0]  h_pc;
  logic            ev_takb;
  logic [PCW-1:0]  ev_target, ev_redirect;

  assign in_ready_o = (count_q < DEPTH_C) & ~flush_i;
  assign push       = in_valid_i & in_ready_o;
  assign xfer       = s2_valid_q & out_ready_i;
  assign s1_adv     = ~s2_valid_q | out_ready_i;
  assign s1_move    = s1_valid_q & s1_adv;
  // Head is read straight from storage, so a same-cycle push never bypasses.
  assign pop        = (count_q != '0) & (~s1_valid_q | s1_adv) & ~flush_i;

  always_comb begin
    h_op        = op_mem[rd_ptr_q];
    h_a         = a_mem[rd_ptr_q];
    h_b         = b_mem[rd_ptr_q];
    h_pc        = pc_mem[rd_ptr_q];
    ev_takb     = 1'b0;
    case (h_op)
      4'd0: ev_takb = (h_a == h_b);
      4'd1: ev_takb = (h_a != h_b);
      4'd2: ev_takb = ($signed(h_a) <  $signed(h_b));
      4'd3: ev_takb = ($signed(h_a) >= $signed(h_b));
      4'd4: ev_takb = (h_a <  h_b);
      4'd5: ev_takb = (h_a >= h_b);
      4'd6: ev_takb = h_a[h_b[BW-1:0]];
      4'd7: ev_takb = ~h_a[h_b[BW-1:0]];
      4'd8: ev_takb = 1'b1;
      default: ev_takb = 1'b0;
    endcase
    ev_target   = h_pc + disp_mem[rd_ptr_q];
    ev_redirect = ev_takb ? ev_target : h_pc + PCW'(INC);
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    s1_valid_d = pop | (s1_valid_q & ~s1_adv);
    s2_valid_d = s1_move | (s2_valid_q & ~out_ready_i);
    br_cnt_d   = br_cnt_q;
    mp_cnt_d   = mp_cnt_q;
    // Statistics saturate and deliberately survive a flush.
    if (xfer && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNTW'(1);
    if (xfer && s2_mp_q && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNTW'(1);
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= op_i;
      a_mem[wr_ptr_q]    <= a_i;
      b_mem[wr_ptr_q]    <= b_i;
      pc_mem[wr_ptr_q]   <= pc_i;
      disp_mem[wr_ptr_q] <= disp_i;
      pred_mem[wr_ptr_q] <= pred_taken_i;
      tag_mem[wr_ptr_q]  <= tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
      s1_takb_q     <= 1'b0;
      s1_mp_q       <= 1'b0;
      s1_target_q   <= '0;
      s1_redirect_q <= '0;
      s1_tag_q      <= '0;
      s2_takb_q     <= 1'b0;
      s2_mp_q       <= 1'b0;
      s2_target_q   <= '0;
      s2_redirect_q <= '0;
      s2_tag_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
      if (pop) begin
        s1_takb_q     <= ev_takb;
        s1_mp_q       <= ev_takb ^ pred_mem[rd_ptr_q];
        s1_target_q   <= ev_target;
        s1_redirect_q <= ev_redirect;
        s1_tag_q      <= tag_mem[rd_ptr_q];
      end
      if (s1_move) begin
        s2_takb_q     <= s1_takb_q;
        s2_mp_q       <= s1_mp_q;
        s2_target_q   <= s1_target_q;
        s2_redirect_q <= s1_redirect_q;
        s2_tag_q      <= s1_tag_q;
      end
    end
  end

  assign out_valid_o   = s2_valid_q;
  assign takb_o        = s2_takb_q;
  assign target_o      = s2_target_q;
  assign redirect_pc_o = s2_redirect_q;
  assign mispredict_o  = s2_mp_q;
  assign tag_o         = s2_tag_q;
  assign br_count_o    = br_cnt_q;
  assign mp_count_o    = mp_cnt_q;
endmodule

// File: tb/tb_any1_branch_eval_pipe.sv
// tb/tb_any1_branch_eval_pipe.sv - scoreboard bench for any1_branch_eval_pipe against a behavioural branch model.
module tb_any1_branch_eval_pipe;
  typedef struct packed {
    logic [3:0] op; logic [63:0] a; logic [63:0] b;
    logic [31:0] pc; logic [31:0] disp; logic pred; logic [5:0] tag;
  } req_t;
  typedef struct packed {
    logic takb; logic [31:0] target; logic [31:0] redirect; logic mp; logic [5:0] tag;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic [31:0] pc = '0, disp = '0;
  logic        pred = 1'b0;
  logic [5:0]  tag = '0;
  logic        in_ready, out_valid, takb, mp;
  logic [31:0] target, redirect, br_count, mp_count;
  logic [5:0]  tag_o;
  logic        in_ready4, out_valid4, takb4, mp4;
  logic [31:0] target4, redirect4;
  logic [5:0]  tag_o4;
  logic [3:0]  br_count4, mp_count4;

  any1_branch_eval_pipe dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .pc_i(pc), .disp_i(disp), .pred_taken_i(pred), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .takb_o(takb), .target_o(target),
    .redirect_pc_o(redirect), .mispredict_o(mp), .tag_o(tag_o),
    .br_count_o(br_count), .mp_count_o(mp_count));

  any1_branch_eval_pipe #(.CNTW(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .op_i(op), .a_i(a), .b_i(b), .pc_i(pc), .disp_i(disp), .pred_taken_i(pred), .tag_i(tag),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .takb_o(takb4), .target_o(target4),
    .redirect_pc_o(redirect4), .mispredict_o(mp4), .tag_o(tag_o4),
    .br_count_o(br_count4), .mp_count_o(mp_count4));

  always #5 clk = ~clk;

  int   vecs = 0, errs = 0, n_br = 0, n_mp = 0, stalls = 0;
  exp_t sb[$];
  exp_t hold_v;
  logic prev_hold = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input req_t r);
    exp_t e;
    logic t;
    case (r.op)
      4'd0: t = (r.a == r.b);
      4'd1: t = (r.a != r.b);
      4'd2: t = ($signed(r.a) <  $signed(r.b));
      4'd3: t = ($signed(r.a) >= $signed(r.b));
      4'd4: t = (r.a <  r.b);
      4'd5: t = (r.a >= r.b);
      4'd6: t = ((r.a >> (r.b % 64)) & 64'd1) != 64'd0;
      4'd7: t = ((r.a >> (r.b % 64)) & 64'd1) == 64'd0;
      4'd8: t = 1'b1;
      default: t = 1'b0;
    endcase
    e.takb     = t;
    e.target   = r.pc + r.disp;
    e.redirect = t ? e.target : r.pc + 32'd4;
    e.mp       = (t != r.pred);
    e.tag      = r.tag;
    return e;
  endfunction

  function automatic req_t mk(input logic [3:0] o, input logic [63:0] ra, input logic [63:0] rb,
                              input logic [31:0] rpc, input logic [31:0] rd, input logic rp,
                              input logic [5:0] rt);
    return '{op: o, a: ra, b: rb, pc: rpc, disp: rd, pred: rp, tag: rt};
  endfunction

  function automatic req_t rnd_req(input logic [5:0] rt);
    req_t r;
    r.op   = 4'($urandom_range(0, 15));
    r.a    = {$urandom, $urandom};
    r.b    = ($urandom_range(0, 3) == 0) ? r.a : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) r.b = 64'($urandom_range(0, 200));
    r.pc   = $urandom;
    r.disp = $urandom;
    r.pred = 1'($urandom_range(0, 1));
    r.tag  = rt;
    return r;
  endfunction

  task automatic send(input req_t r);
    int w;
    w = 0;
    op = r.op; a = r.a; b = r.b; pc = r.pc; disp = r.disp; pred = r.pred; tag = r.tag;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      w++;
      if (w > 100) begin
        vecs++; errs++;
        $display("FAIL send_timeout: tag %0d not accepted in %0d cycles", r.tag, w);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (w != 0) stalls++;
    @(posedge clk);
    sb.push_back(model(r));
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard monitor: checks every output transfer and output stability under backpressure.
  always @(negedge clk) begin
    exp_t got, e;
    got = {takb, target, redirect, mp, tag_o};
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        vecs++;
        if (!out_valid || got != hold_v) begin
          errs++;
          $display("FAIL hold_stable: got v=%0b %0h expected v=1 %0h", out_valid, got, hold_v);
        end
      end
      if (out_valid && out_ready) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL unexpected_output: got tag %0d expected no output", tag_o);
        end else begin
          e = sb.pop_front();
          if (got != e || br_count !== 32'(n_br) || mp_count !== 32'(n_mp) ||
              br_count4 !== ((n_br > 15) ? 4'hF : 4'(n_br)) ||
              mp_count4 !== ((n_mp > 15) ? 4'hF : 4'(n_mp)) || tag_o4 !== e.tag) begin
            errs++;
            $display("FAIL result: got %0h br=%0d mp=%0d br4=%0d expected %0h br=%0d mp=%0d",
                     got, br_count, mp_count, br_count4, e, n_br, n_mp);
          end
          n_br++;
          if (e.mp) n_mp++;
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      hold_v    = got;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_t r6;
    logic done;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_takb", takb, 0);
    chk("rst_target", target, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_br_count", br_count, 0);
    chk("rst_mp_count", mp_count, 0);
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(mk(4'd0, 64'h5, 64'h5, 32'h1000, 32'h20, 1'b0, 6'd1));
    @(negedge clk);
    @(negedge clk); chk("latency_n1", out_valid, 0);
    @(negedge clk); chk("latency_n2", out_valid, 1);
    @(negedge clk);
    chk("first_br_count", br_count, 1);
    chk("first_mp_count", mp_count, 1);
    @(posedge clk); #1;

    send(mk(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h2000, 32'h40, 1'b1, 6'd2));
    send(mk(4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h2000, 32'h40, 1'b1, 6'd3));
    send(mk(4'd6, 64'h8000_0000_0000_0000, 64'h13F, 32'h3000, 32'hFFFF_FFF0, 1'b0, 6'd4));
    send(mk(4'd7, 64'h8000_0000_0000_0000, 64'h13F, 32'h3000, 32'hFFFF_FFF0, 1'b0, 6'd5));
    send(mk(4'd8, 64'h0, 64'h0, 32'hFFFF_FFFC, 32'h8, 1'b0, 6'd6));
    send(mk(4'd12, 64'h1, 64'h1, 32'hFFFF_FFFC, 32'h8, 1'b1, 6'd7));
    send(mk(4'd3, 64'h8000_0000_0000_0000, 64'h0, 32'h10, 32'h10, 1'b0, 6'd8));
    repeat (4) @(posedge clk);
    #1;

    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(rnd_req(6'(i)));
    r6 = rnd_req(6'd6);
    op = r6.op; a = r6.a; b = r6.b; pc = r6.pc; disp = r6.disp; pred = r6.pred; tag = r6.tag;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    fork
      send(r6);
      begin
        out_ready = 1'b1;
        repeat (6) begin
          @(negedge clk);
          chk("drain_streak", out_valid, 1);
        end
      end
    join
    @(posedge clk); #1;

    stalls = 0;
    for (int i = 0; i < 100; i++) send(rnd_req(6'(i)));
    chk("throughput_stalls", stalls, 0);

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) send(rnd_req(6'(i)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rnd_req(6'(40 + i)));
    r6 = rnd_req(6'd63);
    op = r6.op; a = r6.a; b = r6.b; pc = r6.pc; disp = r6.disp; pred = r6.pred; tag = r6.tag;
    in_valid = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    sb.delete();
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_no_output", out_valid, 0);
    chk("flush_br_count", br_count, 32'(n_br));
    chk("flush_mp_count", mp_count, 32'(n_mp));
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) send(rnd_req(6'(i)));
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("final_empty", sb.size(), 0);
    chk("sat4_br_count", br_count4, 4'hF);
    chk("final_br_count", br_count, 32'(n_br));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
